// File: rtl/branch_flush_controller_pkg.sv
// Shared definitions for the branch flush controller: ROB sizing, FSM encoding
// and the per-ROB-entry branch record.
package branch_flush_controller_pkg;

  localparam int unsigned ROB_IDX_W = 4;
  localparam int unsigned ROB_SIZE  = 32'd1 << ROB_IDX_W;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 4;   // holds FLUSH_CYCLES-1 for FLUSH_CYCLES up to 15

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic              pred_taken;
    logic              resolved;
    logic              mispredict;
    logic [DATA_W-1:0] target;
  } bit_entry_t;

endpackage

// File: rtl/branch_flush_controller_branch_info_table.sv
// Per-ROB-entry branch record storage.
// Ports: clk_in/rst_in; issue write port (issue_we_i, issue_id_i, issue_pred_i);
// BCU write port (bcu_we_i, bcu_id_i, bcu_taken_i, bcu_value_i); clear_all_i wipes
// resolved/mispredict in every entry; combinational read port (rd_id_i -> rd_entry_c_o).
module branch_info_table
  import branch_flush_controller_pkg::*;
#(
  parameter int unsigned TBL_IDX_W = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 issue_we_i,
  input  logic [TBL_IDX_W-1:0] issue_id_i,
  input  logic                 issue_pred_i,
  input  logic                 bcu_we_i,
  input  logic [TBL_IDX_W-1:0] bcu_id_i,
  input  logic                 bcu_taken_i,
  input  logic [DATA_W-1:0]    bcu_value_i,
  input  logic                 clear_all_i,
  input  logic [TBL_IDX_W-1:0] rd_id_i,
  output bit_entry_t           rd_entry_c_o
);

  localparam int unsigned TBL_SIZE = 32'd1 << TBL_IDX_W;

  bit_entry_t tbl_q [TBL_SIZE];
  bit_entry_t tbl_d [TBL_SIZE];

  logic issue_hit;
  logic bcu_hit;

  // Id 0 is the "no entry" encoding and is never written; an issue to the
  // same id as a BCU result in the same cycle takes priority.
  assign issue_hit = issue_we_i && (issue_id_i != '0);
  assign bcu_hit   = bcu_we_i && (bcu_id_i != '0) && !(issue_hit && (issue_id_i == bcu_id_i));

  // Next-state for the whole table.
  always_comb begin
    tbl_d = tbl_q;
    if (bcu_hit) begin
      tbl_d[bcu_id_i].resolved   = 1'b1;
      tbl_d[bcu_id_i].target     = bcu_value_i;
      tbl_d[bcu_id_i].mispredict = (bcu_taken_i != tbl_q[bcu_id_i].pred_taken);
    end
    if (issue_hit) begin
      tbl_d[issue_id_i].pred_taken = issue_pred_i;
      tbl_d[issue_id_i].resolved   = 1'b0;
      tbl_d[issue_id_i].mispredict = 1'b0;
    end
    // Flush entry invalidates every outstanding result, including any landing now.
    if (clear_all_i) begin
      for (int i = 0; i < int'(TBL_SIZE); i++) begin
        tbl_d[i].resolved   = 1'b0;
        tbl_d[i].mispredict = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(TBL_SIZE); i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

  // Reads the registered table only: no bypass from a same-cycle BCU write.
  assign rd_entry_c_o = tbl_q[rd_id_i];

endmodule

// File: rtl/branch_flush_controller.sv
// Branch resolution sequencer: records predictions at issue, captures BCU
// outcomes, and on commit of a mispredicted branch runs flush -> drain recovery.
// Ports: clk_in/rst_in; issue_* (branch issue), bcu_* (resolution result),
// commit_* (ROB commit); outputs flush_out, stall_out, redirect_valid/pc,
// bp_update_valid/pc/taken -- all registered.
module branch_flush_controller
  import branch_flush_controller_pkg::*;
#(
  parameter int unsigned ROB_IDX_W    = branch_flush_controller_pkg::ROB_IDX_W,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 issue_valid,
  input  logic [ROB_IDX_W-1:0] issue_rob_id,
  input  logic                 issue_pred_taken,
  input  logic [ROB_IDX_W-1:0] bcu_rob_id,
  input  logic                 bcu_taken,
  input  logic [DATA_W-1:0]    bcu_value,
  input  logic                 commit_valid,
  input  logic [ROB_IDX_W-1:0] commit_rob_id,
  input  logic                 commit_is_branch,
  input  logic [DATA_W-1:0]    commit_pc,
  output logic                 flush_out,
  output logic                 stall_out,
  output logic                 redirect_valid,
  output logic [DATA_W-1:0]    redirect_pc,
  output logic                 bp_update_valid,
  output logic [DATA_W-1:0]    bp_update_pc,
  output logic                 bp_update_taken
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              flush_q, flush_d;
  logic              stall_q, stall_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
  logic              bp_valid_q, bp_valid_d;
  logic [DATA_W-1:0] bp_pc_q, bp_pc_d;
  logic              bp_taken_q, bp_taken_d;

  logic       accept;
  logic       commit_br;
  logic       commit_mis;
  bit_entry_t rd_entry;

  // All inputs are dropped while recovering.
  assign accept     = (state_q == ST_IDLE);
  assign commit_br  = accept && commit_valid && commit_is_branch;
  // An unresolved entry is treated as correctly predicted.
  assign commit_mis = commit_br && rd_entry.resolved && rd_entry.mispredict;

  branch_info_table #(
    .TBL_IDX_W (ROB_IDX_W)
  ) u_table (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .issue_we_i   (accept && issue_valid),
    .issue_id_i   (issue_rob_id),
    .issue_pred_i (issue_pred_taken),
    .bcu_we_i     (accept),
    .bcu_id_i     (bcu_rob_id),
    .bcu_taken_i  (bcu_taken),
    .bcu_value_i  (bcu_value),
    .clear_all_i  (commit_mis),
    .rd_id_i      (commit_rob_id),
    .rd_entry_c_o (rd_entry)
  );

  // State and flush counter registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: FLUSH holds for FLUSH_CYCLES cycles, DRAIN for one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (commit_mis) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output next values; registered below so they track state_d one edge later.
  always_comb begin
    flush_d          = (state_d == ST_FLUSH);
    stall_d          = (state_d != ST_IDLE);
    redirect_valid_d = commit_mis;
    redirect_pc_d    = commit_mis ? rd_entry.target : '0;
    bp_valid_d       = commit_br;
    bp_pc_d          = commit_br ? commit_pc : '0;
    // Stored direction: the prediction, flipped if resolved as mispredicted.
    bp_taken_d       = commit_br &&
                       (rd_entry.pred_taken ^ (rd_entry.resolved && rd_entry.mispredict));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      bp_valid_q       <= 1'b0;
      bp_pc_q          <= '0;
      bp_taken_q       <= 1'b0;
    end else begin
      flush_q          <= flush_d;
      stall_q          <= stall_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      bp_valid_q       <= bp_valid_d;
      bp_pc_q          <= bp_pc_d;
      bp_taken_q       <= bp_taken_d;
    end
  end

  assign flush_out       = flush_q;
  assign stall_out       = stall_q;
  assign redirect_valid  = redirect_valid_q;
  assign redirect_pc     = redirect_pc_q;
  assign bp_update_valid = bp_valid_q;
  assign bp_update_pc    = bp_pc_q;
  assign bp_update_taken = bp_taken_q;

endmodule

// File: tb/tb_branch_flush_controller.sv
// Scoreboard bench for branch_flush_controller: a cycle-stamped reference model
// queues expected output events; a negedge monitor pops and compares them.
module tb_branch_flush_controller;

  localparam int unsigned W  = 4;
  localparam int unsigned FC = 2;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          issue_valid = 1'b0;
  logic [W-1:0]  issue_rob_id = '0;
  logic          issue_pred_taken = 1'b0;
  logic [W-1:0]  bcu_rob_id = '0;
  logic          bcu_taken = 1'b0;
  logic [31:0]   bcu_value = '0;
  logic          commit_valid = 1'b0;
  logic [W-1:0]  commit_rob_id = '0;
  logic          commit_is_branch = 1'b0;
  logic [31:0]   commit_pc = '0;
  logic          flush_out, stall_out, redirect_valid, bp_update_valid, bp_update_taken;
  logic [31:0]   redirect_pc, bp_update_pc;

  branch_flush_controller #(.ROB_IDX_W(W), .FLUSH_CYCLES(FC)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .issue_valid      (issue_valid),
    .issue_rob_id     (issue_rob_id),
    .issue_pred_taken (issue_pred_taken),
    .bcu_rob_id       (bcu_rob_id),
    .bcu_taken        (bcu_taken),
    .bcu_value        (bcu_value),
    .commit_valid     (commit_valid),
    .commit_rob_id    (commit_rob_id),
    .commit_is_branch (commit_is_branch),
    .commit_pc        (commit_pc),
    .flush_out        (flush_out),
    .stall_out        (stall_out),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .bp_update_valid  (bp_update_valid),
    .bp_update_pc     (bp_update_pc),
    .bp_update_taken  (bp_update_taken)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          cyc;
    logic        flush;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        bv;
    logic [31:0] bpc;
    logic        bt;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_cmp = 0;
  int  n_fail = 0;
  int  cyc = 0;

  // Reference model: predicted direction, resolved flag, resolved direction and target.
  logic        m_pred [16];
  logic        m_res  [16];
  logic        m_tkn  [16];
  logic [31:0] m_tgt  [16];
  int          idle_at = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_pred[i] = 1'b0; m_res[i] = 1'b0; m_tkn[i] = 1'b0; m_tgt[i] = '0;
    end
    idle_at = 0;
    exp_q.delete();
  endtask

  function automatic void push_ev(int c, logic f, logic s, logic rv, logic [31:0] rpc,
                                  logic bv, logic [31:0] bpc, logic bt);
    ev_t e;
    e.cyc = c; e.flush = f; e.stall = s; e.rv = rv; e.rpc = rpc;
    e.bv = bv; e.bpc = bpc; e.bt = bt;
    exp_q.push_back(e);
  endfunction

  // Drive one cycle of inputs, update the model, advance to just after the next edge.
  task automatic step(input logic iv, input logic [W-1:0] iid, input logic ip,
                      input logic [W-1:0] bid, input logic bt, input logic [31:0] bval,
                      input logic cv, input logic [W-1:0] cid, input logic cb,
                      input logic [31:0] cpc);
    int   t;
    logic mis;
    logic tk;
    issue_valid = iv; issue_rob_id = iid; issue_pred_taken = ip;
    bcu_rob_id = bid; bcu_taken = bt; bcu_value = bval;
    commit_valid = cv; commit_rob_id = cid; commit_is_branch = cb; commit_pc = cpc;
    t   = cyc;
    mis = 1'b0;
    if (t >= idle_at) begin
      if (cv && cb) begin
        mis = m_res[cid] && (m_tkn[cid] != m_pred[cid]);
        tk  = m_res[cid] ? m_tkn[cid] : m_pred[cid];
        push_ev(t + 1, mis, mis, mis, m_tgt[cid], 1'b1, cpc, tk);
        if (mis) begin
          for (int k = 2; k <= int'(FC); k++) push_ev(t + k, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
          push_ev(t + int'(FC) + 1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
          idle_at = t + int'(FC) + 2;
        end
      end
      if (bid != 0 && !(iv && iid == bid)) begin
        m_res[bid] = 1'b1; m_tkn[bid] = bt; m_tgt[bid] = bval;
      end
      if (iv && iid != 0) begin
        m_pred[iid] = ip; m_res[iid] = 1'b0;
      end
      if (mis) for (int i = 0; i < 16; i++) m_res[i] = 1'b0;
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (flush_out || stall_out || redirect_valid || redirect_pc != 0 ||
        bp_update_valid || bp_update_pc != 0 || bp_update_taken) begin
      n_fail++;
      $display("FAIL %s: got flush=%b stall=%b rv=%b rpc=%h bv=%b bpc=%h bt=%b, required all zero",
               name, flush_out, stall_out, redirect_valid, redirect_pc,
               bp_update_valid, bp_update_pc, bp_update_taken);
    end
  endtask

  // Monitor: every cycle with any active output must match the next queued event.
  always @(negedge clk_in) begin
    if (!rst_in && (flush_out || stall_out || redirect_valid || bp_update_valid)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output cyc=%0d: got flush=%b stall=%b rv=%b bv=%b, required none",
                 cyc, flush_out, stall_out, redirect_valid, bp_update_valid);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || flush_out != mon_e.flush || stall_out != mon_e.stall ||
            redirect_valid != mon_e.rv || bp_update_valid != mon_e.bv ||
            (mon_e.rv && redirect_pc != mon_e.rpc) ||
            (mon_e.bv && (bp_update_pc != mon_e.bpc || bp_update_taken != mon_e.bt))) begin
          n_fail++;
          $display("FAIL output_event: got cyc=%0d f=%b s=%b rv=%b rpc=%h bv=%b bpc=%h bt=%b; required cyc=%0d f=%b s=%b rv=%b rpc=%h bv=%b bpc=%h bt=%b",
                   cyc, flush_out, stall_out, redirect_valid, redirect_pc, bp_update_valid,
                   bp_update_pc, bp_update_taken, mon_e.cyc, mon_e.flush, mon_e.stall,
                   mon_e.rv, mon_e.rpc, mon_e.bv, mon_e.bpc, mon_e.bt);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_zero("reset_state");
    rst_in = 1'b0;
    idle(1);

    // Correct prediction.
    step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 3, 1, 32'h100, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3, 1, 32'h80);
    idle(2);

    // Mispredict, then inputs during FLUSH are ignored.
    step(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 5, 1, 32'h200, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 5, 1, 32'h50);
    step(0, 0, 0, 7, 1, 32'h700, 1, 7, 1, 32'h70);
    idle(int'(FC) + 1);
    step(0, 0, 0, 0, 0, 0, 1, 7, 1, 32'h74);
    idle(1);

    // Same-id issue/BCU collision leaves the entry unresolved.
    step(1, 2, 0, 2, 1, 32'h300, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 2, 1, 32'h20);
    idle(2);

    // Wrap boundary: ids 15 and 1, flush on 15 clears id 1.
    step(1, 15, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 15, 1, 32'hF00, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h10, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 15, 1, 32'hF0);
    idle(int'(FC) + 1);
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h14);
    idle(2);

    // Non-branch commit produces nothing.
    step(0, 0, 0, 0, 0, 0, 1, 3, 0, 32'h90);
    idle(2);

    // Reset during the second flush cycle.
    step(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4, 0, 32'h400, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 4, 1, 32'h40);
    idle(1);
    #2;
    rst_in = 1'b1;
    model_reset();
    #1;
    check_zero("reset_async_mid_flush");
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    check_zero("after_reset_release");
    step(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 6, 1, 32'h600, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 6, 1, 32'h60);
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      step(1'($urandom_range(0, 1)), W'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) != 0) ? W'($urandom_range(1, 15)) : W'(0),
           1'($urandom_range(0, 1)), $urandom,
           ($urandom_range(0, 2) == 0), W'($urandom_range(1, 15)),
           ($urandom_range(0, 3) != 0), $urandom);
    end
    idle(int'(FC) + 4);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL events_drained: got %0d pending events, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
